// File: rtl/shift_flag_wb.sv
// Shifter flag/writeback stage: computes {P,O,S,Z,C} at push time and buffers results in a 2-entry FIFO.
// Optional macro SHIFT_PARITY_FLAG_EN builds the parity flag; otherwise P is tied to 0.
module shift_flag_wb #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_res,
  input  logic             in_coutR,
  input  logic [3:0]       in_coutL,
  input  logic [3:0]       in_sz,
  input  logic             in_dir,
  input  logic             in_arith,
  input  logic [5:0]       in_cnt,
  input  logic             in_src_msb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [4:0]       out_flags,
  output logic             out_flag_we,
  output logic [TAG_W-1:0] out_tag
);

  // Returns {O,S,Z,C}; caller zeroes them when the masked count is 0.
  function automatic logic [3:0] calc_flags(
    input logic [WIDTH-1:0] res,
    input logic             sz64,
    input logic             dir,
    input logic             arith,
    input logic             coutr,
    input logic [3:0]       coutl,
    input logic [5:0]       cnt_m,
    input logic             src_msb
  );
    logic c, z, s, o;
    c = dir ? coutr : (sz64 ? coutl[3] : coutl[2]);
    z = sz64 ? (res == '0) : (res[31:0] == 32'd0);
    s = sz64 ? res[WIDTH-1] : res[31];
    o = 1'b0;
    if (cnt_m == 6'd1)
      o = dir ? (arith ? 1'b0 : src_msb) : (s ^ c);
    return {o, s, z, c};
  endfunction

  logic             sz64;
  logic [5:0]       cnt_m;
  logic             push;
  logic             pop;
  logic [1:0]       count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             vld_p1;
  logic [3:0]       flags_p0;
  logic             we_p0;
  logic [WIDTH-1:0] res_p0;

  logic [WIDTH-1:0] res_p1   [2];
  logic [3:0]       flags_p1 [2];
  logic             we_p1    [2];
  logic [TAG_W-1:0] tag_p1   [2];

  // Only the 64/32-bit encodings matter; the narrower size/carry bits are ignored.
  logic unused_sz;
  assign unused_sz = ^{in_sz[2:0], in_coutL[1:0]};

  assign sz64     = in_sz[3];
  assign cnt_m    = sz64 ? in_cnt : {1'b0, in_cnt[4:0]};
  assign we_p0    = (cnt_m != 6'd0);
  assign flags_p0 = we_p0 ? calc_flags(in_res, sz64, in_dir, in_arith, in_coutR,
                                       in_coutL, cnt_m, in_src_msb) : 4'd0;
  assign res_p0   = sz64 ? in_res : {{(WIDTH-32){1'b0}}, in_res[31:0]};

  assign in_ready = (count != 2'd2) && !rst;
  assign vld_p1   = (count != 2'd0);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = vld_p1 && out_ready && !flush;

  // Stage p0 -> p1: FIFO control
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_p1[wr_ptr]   <= res_p0;
      flags_p1[wr_ptr] <= flags_p0;
      we_p1[wr_ptr]    <= we_p0;
      tag_p1[wr_ptr]   <= in_tag;
    end
  end

`ifdef SHIFT_PARITY_FLAG_EN
  logic par_p1 [2];

  always_ff @(posedge clk) begin
    if (push)
      par_p1[wr_ptr] <= we_p0 ? ~^in_res[7:0] : 1'b0;
  end

  assign out_flags = vld_p1 ? {par_p1[rd_ptr], flags_p1[rd_ptr]} : 5'd0;
`else
  assign out_flags = vld_p1 ? {1'b0, flags_p1[rd_ptr]} : 5'd0;
`endif

  // Stage p1 outputs: storage is not reset, so the payload is gated by valid.
  assign out_valid   = vld_p1;
  assign out_res     = vld_p1 ? res_p1[rd_ptr] : '0;
  assign out_flag_we = vld_p1 ? we_p1[rd_ptr] : 1'b0;
  assign out_tag     = vld_p1 ? tag_p1[rd_ptr] : '0;

endmodule
